// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix datapath result path.
// A result set packs the four 2x2 products row-major, R1C1 in the top element.
package matrix_pkg;

    localparam int RESULT_W    = 16;
    localparam int NUM_RESULTS = 4;
    localparam int ELEM_W      = 8;
    localparam int IDX_W       = $clog2(NUM_RESULTS);

    typedef logic [NUM_RESULTS-1:0][RESULT_W-1:0] result_set_t;

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } stream_state_t;

    // Element 0 is result1, which sits in the most significant slice of the set.
    function automatic logic [RESULT_W-1:0] get_elem(input result_set_t rs,
                                                     input logic [IDX_W-1:0] idx);
        return rs[IDX_W'(NUM_RESULTS - 1) - idx];
    endfunction

endpackage

// File: rtl/result_unloader_if.sv
// Result stream: one element per beat with its position in the set.
interface result_unloader_if;
    import matrix_pkg::*;

    logic [RESULT_W-1:0] out_data;
    logic [IDX_W-1:0]    out_index;
    logic                out_last;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output out_data,
        output out_index,
        output out_last,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_index,
        input  out_last,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/result_slot_buffer.sv
// Two-entry ping-pong FIFO of complete result sets.
// rd_data looks ahead past a slot being freed this cycle, so the consumer can
// register the next set's first element on the same edge that frees the slot.
module result_slot_buffer
    import matrix_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  result_set_t wr_data,
    input  logic        rd_free,
    output logic [1:0]  count,
    output logic        full,
    output logic        empty,
    output result_set_t rd_data
);

    result_set_t mem [2];
    logic        wr_ptr;
    logic        rd_ptr;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign rd_data = mem[rd_ptr ^ rd_free];

    // Pointer and occupancy bookkeeping; a write and a free in one cycle cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en)
                wr_ptr <= ~wr_ptr;
            if (rd_free)
                rd_ptr <= ~rd_ptr;
            case ({wr_en, rd_free})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Slot storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/result_unloader.sv
// Captures multiplier results on the rising edge of the done flag, queues up
// to two sets and streams them one element per beat over valid/ready.
// All stream outputs are registered; next values are computed from the set
// that will be at the head after this edge, including a set captured now.
module result_unloader
    import matrix_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [RESULT_W-1:0] result1,
    input  logic [RESULT_W-1:0] result2,
    input  logic [RESULT_W-1:0] result3,
    input  logic [RESULT_W-1:0] result4,
    input  logic                matrix_multiplication_done,
    result_unloader_if.master   stream,
    output logic                busy,
    output logic                overflow
);

    logic                done_q;
    logic                capture;
    logic                beat;
    logic                last_acc;
    logic                wr_en;
    logic                post_free_empty;
    logic [1:0]          count;
    logic                full;
    logic                empty;
    result_set_t         captured;
    result_set_t         rd_data;
    result_set_t         next_set;
    stream_state_t       state;
    stream_state_t       state_nxt;
    logic [IDX_W-1:0]    idx_nxt;
    logic [RESULT_W-1:0] data_nxt;
    logic                valid_nxt;
    logic                last_nxt;
    logic                busy_nxt;

    assign captured = {result1, result2, result3, result4};
    assign capture  = matrix_multiplication_done && !done_q;
    assign beat     = stream.out_valid && stream.out_ready;
    assign last_acc = beat && stream.out_last;
    // A slot freed by the final beat this cycle is already available to a capture.
    assign wr_en    = capture && (!full || last_acc);
    // True when no stored set remains once this cycle's free has taken effect.
    assign post_free_empty = empty || (last_acc && count == 2'd1);
    assign next_set = post_free_empty ? captured : rd_data;

    result_slot_buffer u_slot_buffer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (captured),
        .rd_free (last_acc),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .rd_data (rd_data)
    );

    // Done edge detection and sticky record of dropped sets.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done_q <= matrix_multiplication_done;
            if (capture && !wr_en)
                overflow <= 1'b1;
        end
    end

    // Stream FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Stream FSM next state: leave STREAM only when nothing is left to send.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!empty || wr_en) state_nxt = S_STREAM;
            S_STREAM: if (last_acc && post_free_empty && !wr_en) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered stream outputs; a stall leaves all of them unchanged.
    always_comb begin
        idx_nxt = stream.out_index;
        if (state_nxt != S_STREAM)
            idx_nxt = '0;
        else if (beat)
            idx_nxt = stream.out_last ? '0 : stream.out_index + 1'b1;
        valid_nxt = (state_nxt == S_STREAM);
        last_nxt  = valid_nxt && (idx_nxt == IDX_W'(NUM_RESULTS - 1));
        data_nxt  = valid_nxt ? get_elem(next_set, idx_nxt) : '0;
        busy_nxt  = !post_free_empty || wr_en;
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stream.out_valid <= 1'b0;
            stream.out_data  <= '0;
            stream.out_index <= '0;
            stream.out_last  <= 1'b0;
            busy             <= 1'b0;
        end else begin
            stream.out_valid <= valid_nxt;
            stream.out_data  <= data_nxt;
            stream.out_index <= idx_nxt;
            stream.out_last  <= last_nxt;
            busy             <= busy_nxt;
        end
    end

endmodule
